// File: rtl/reg_file_8x16.sv
// Eight-entry register file fed by a one-hot write decoder, with two registered
// read ports (write-first bypass), a sequential clear engine and one-hot checking.
module reg_file_8x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       we_onehot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_sel_a,
    input  logic [2:0]       rd_sel_b,
    input  logic             clr_req,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             busy,
    output logic             wr_err
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              cnt, cnt_nxt;
    logic [7:0][WIDTH-1:0]   regs, regs_nxt;
    logic                    we_any, we_multi, wr_fire, err_nxt;

    assign we_any   = |we_onehot;
    assign we_multi = (we_onehot & (we_onehot - 8'd1)) != 8'd0;
    assign wr_fire  = (state == IDLE) && !clr_req && we_any && !we_multi;
    // Any write attempt that cannot land is flagged: multi-hot, during clear, or colliding with a clear request.
    assign err_nxt  = we_any && (we_multi || (state == CLEAR) || clr_req);

    // Per-entry next value; reads sample this so a same-edge update is bypassed.
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_ent
            assign regs_nxt[i] = ((state == CLEAR) && (cnt == 3'(i))) ? '0 :
                                 (wr_fire && we_onehot[i])            ? wr_data :
                                                                        regs[i];
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 3'd0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            regs      <= '0;
            rd_data_a <= '0;
            rd_data_b <= '0;
            wr_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            regs      <= regs_nxt;
            rd_data_a <= regs_nxt[rd_sel_a];
            rd_data_b <= regs_nxt[rd_sel_b];
            wr_err    <= err_nxt;
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_reg_file_8x16.sv
// Bench for reg_file_8x16: directed vector table, clear/reset sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_reg_file_8x16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  we_onehot = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd_sel_a = '0, rd_sel_b = '0;
    logic        clr_req = 1'b0;
    logic [15:0] rd_data_a, rd_data_b;
    logic        busy, wr_err;

    int n_chk = 0, n_pass = 0;

    reg_file_8x16 #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .we_onehot(we_onehot), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .clr_req(clr_req),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy(busy), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [15:0] m_reg [8];
    int          m_clr_left, m_clr_idx;
    logic [15:0] exp_a, exp_b;
    logic        exp_busy, exp_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_reg[k] = '0;
        m_clr_left = 0;
        m_clr_idx  = 0;
    endtask

    task automatic model_step(input logic [7:0] we, input logic [15:0] wd,
                              input logic [2:0] sa, input logic [2:0] sb, input logic clr);
        exp_err = (we != 0) && (($countones(we) > 1) || (m_clr_left > 0) || clr);
        if (m_clr_left > 0) begin
            m_reg[m_clr_idx] = '0;
            m_clr_idx++;
            m_clr_left--;
        end else if (clr) begin
            m_clr_left = 8;
            m_clr_idx  = 0;
        end else if ($countones(we) == 1) begin
            for (int k = 0; k < 8; k++) if (we[k]) m_reg[k] = wd;
        end
        exp_a    = m_reg[sa];
        exp_b    = m_reg[sb];
        exp_busy = (m_clr_left > 0);
    endtask

    // Apply one cycle of inputs, advance model, check all outputs after the edge.
    task automatic step(input string tag, input logic [7:0] we, input logic [15:0] wd,
                        input logic [2:0] sa, input logic [2:0] sb, input logic clr);
        we_onehot = we; wr_data = wd; rd_sel_a = sa; rd_sel_b = sb; clr_req = clr;
        model_step(we, wd, sa, sb, clr);
        @(posedge clk); #1;
        chk({tag, ".rd_a"}, rd_data_a, exp_a);
        chk({tag, ".rd_b"}, rd_data_b, exp_b);
        chk({tag, ".busy"}, {15'd0, busy}, {15'd0, exp_busy});
        chk({tag, ".wr_err"}, {15'd0, wr_err}, {15'd0, exp_err});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we_onehot = '0; wr_data = '0; rd_sel_a = '0; rd_sel_b = '0; clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rd_a", rd_data_a, 16'h0);
        chk("rst.rd_b", rd_data_b, 16'h0);
        chk("rst.busy", {15'd0, busy}, 16'h0);
        chk("rst.wr_err", {15'd0, wr_err}, 16'h0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0]  we;
        logic [15:0] wd;
        logic [2:0]  sa, sb;
        logic        clr;
        logic [15:0] ea, eb;
        logic        ebusy, eerr;
    } vec_t;

    vec_t vec [9];

    initial begin
        int busy_cycles;
        logic [7:0] rwe;

        // directed table, applied from a fresh reset
        vec[0] = '{8'h08, 16'hA5A5, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vec[1] = '{8'h00, 16'h0000, 3'd3, 3'd3, 1'b0, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0};
        vec[2] = '{8'h20, 16'h1234, 3'd3, 3'd5, 1'b0, 16'hA5A5, 16'h1234, 1'b0, 1'b0};
        vec[3] = '{8'h24, 16'hFFFF, 3'd2, 3'd5, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1};
        vec[4] = '{8'h00, 16'h0000, 3'd2, 3'd5, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0};
        vec[5] = '{8'h01, 16'h0001, 3'd0, 3'd3, 1'b0, 16'h0001, 16'hA5A5, 1'b0, 1'b0};
        vec[6] = '{8'h80, 16'hBEEF, 3'd7, 3'd0, 1'b0, 16'hBEEF, 16'h0001, 1'b0, 1'b0};
        vec[7] = '{8'hFF, 16'h0000, 3'd7, 3'd0, 1'b0, 16'hBEEF, 16'h0001, 1'b0, 1'b1};
        vec[8] = '{8'h00, 16'h0000, 3'd7, 3'd7, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};

        do_reset();
        for (int v = 0; v < 9; v++) begin
            we_onehot = vec[v].we; wr_data = vec[v].wd;
            rd_sel_a = vec[v].sa; rd_sel_b = vec[v].sb; clr_req = vec[v].clr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.rd_a", v), rd_data_a, vec[v].ea);
            chk($sformatf("vec%0d.rd_b", v), rd_data_b, vec[v].eb);
            chk($sformatf("vec%0d.busy", v), {15'd0, busy}, {15'd0, vec[v].ebusy});
            chk($sformatf("vec%0d.wr_err", v), {15'd0, wr_err}, {15'd0, vec[v].eerr});
        end

        // fill, clear with writes and a repeated clear request during busy
        do_reset();
        for (int k = 0; k < 8; k++) step("fill", 8'(1 << k), 16'h1100 + 16'(k), 3'(k), 3'(7 - k), 1'b0);
        step("clr_go", 8'h00, 16'h0, 3'd0, 3'd1, 1'b1);
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            step("clr_run", (k % 2 == 0) ? 8'(1 << k) : 8'h00, 16'hDEAD, 3'(k), 3'((k + 1) % 8), (k == 3));
            if (busy === 1'b1) busy_cycles++;
        end
        chk("clr.busy_cycles", 16'(busy_cycles), 16'd8);
        for (int k = 0; k < 8; k += 2) step("post_clr", 8'h00, 16'h0, 3'(k), 3'(k + 1), 1'b0);
        step("post_clr_wr", 8'h10, 16'h4444, 3'd4, 3'd0, 1'b0);

        // reset during cycle 4 of a clear
        do_reset();
        for (int k = 0; k < 8; k++) step("fill2", 8'(1 << k), 16'h2200 + 16'(k), 3'(k), 3'(k), 1'b0);
        step("clr2_go", 8'h00, 16'h0, 3'd7, 3'd6, 1'b1);
        for (int k = 0; k < 3; k++) step("clr2_run", 8'h00, 16'h0, 3'd7, 3'd6, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst.busy", {15'd0, busy}, 16'h0);
        chk("midrst.rd_a", rd_data_a, 16'h0);
        chk("midrst.rd_b", rd_data_b, 16'h0);
        #2 reset = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k += 2) step("midrst_rd", 8'h00, 16'h0, 3'(k), 3'(k + 1), 1'b0);
        step("midrst_wr7", 8'h80, 16'h00FF, 3'd7, 3'd6, 1'b0);
        step("midrst_rd7", 8'h00, 16'h0, 3'd6, 3'd7, 1'b0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(3))
                0:       rwe = 8'h00;
                1, 2:    rwe = 8'(1 << $urandom_range(7));
                default: rwe = 8'($urandom);
            endcase
            step("rand", rwe, 16'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)),
                 ($urandom_range(15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
